// File: rtl/bk_adder_mp_scheduler_pkg.sv
// Shared types for the multi-precision adder scheduler.
//   DATA_W   : word width handled per cycle
//   ID_MAX_W : storage width for requester index (covers up to 8 requesters)
//   state_e  : scheduler FSM states
//   rsp_t    : contents of the registered result port
package bk_adder_mp_scheduler_pkg;

    localparam int DATA_W   = 32;
    localparam int ID_MAX_W = 3;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    typedef struct packed {
        logic [DATA_W-1:0]   res;
        logic                cout;
        logic                ovf;
        logic [ID_MAX_W-1:0] id;
        logic                last;
    } rsp_t;

    // Round-robin successor of idx among n requesters.
    function automatic logic [ID_MAX_W-1:0] next_ptr(input logic [ID_MAX_W-1:0] idx, input int n);
        logic [ID_MAX_W-1:0] nxt;
        nxt = '0;
        if (int'(idx) + 1 < n) begin
            nxt = idx + 1'b1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/bk_adder_mp_scheduler_if.sv
// Request/response bundle between requesting engines and the scheduler.
//   req_valid/req_ready : per-requester word handshake
//   req_op1/req_op2     : operand words, LSW first
//   req_sub/req_last    : subtract flag (first word only) and final-word marker
//   rsp_*               : single registered result port with valid/ready
// master = requesting side / result consumer, slave = scheduler.
interface bk_adder_mp_scheduler_if #(
    parameter int NUM_REQ = 4
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0][31:0]  req_op1;
    logic [NUM_REQ-1:0][31:0]  req_op2;
    logic [NUM_REQ-1:0]        req_sub;
    logic [NUM_REQ-1:0]        req_last;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [31:0]               rsp_res;
    logic                      rsp_cout;
    logic                      rsp_ovf;
    logic [ID_W-1:0]           rsp_id;
    logic                      rsp_last;

    modport master (
        output req_valid, req_op1, req_op2, req_sub, req_last, rsp_ready,
        input  req_ready, rsp_valid, rsp_res, rsp_cout, rsp_ovf, rsp_id, rsp_last
    );

    modport slave (
        input  req_valid, req_op1, req_op2, req_sub, req_last, rsp_ready,
        output req_ready, rsp_valid, rsp_res, rsp_cout, rsp_ovf, rsp_id, rsp_last
    );

endinterface

// File: rtl/bk_adder_mp_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req   : request vector
//   ptr   : highest-priority index this round
//   grant : one-hot winner (zero if no request)
//   idx   : binary index of the winner (zero if no request)
module bk_adder_mp_scheduler_rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] idx
);
    localparam int ID_W = $clog2(NUM_REQ);

    always_comb begin
        int  j;
        logic found;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = (int'(ptr) + k) % NUM_REQ;
            if (!found && req[j]) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                idx      = ID_W'(j);
            end
        end
    end

endmodule

// File: rtl/brent_kung_adder_32bit.sv
// 32-bit Brent-Kung parallel-prefix adder.
//   a, b, cin : operands and carry in
//   sum, cout : result word and carry out
module brent_kung_adder_32bit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);
    logic [31:0] p0;
    logic [31:0] g;
    logic [31:0] p;

    always_comb begin
        p0 = a ^ b;
        g  = a & b;
        // Fold carry-in into bit 0 so g[i] becomes the carry out of bit i.
        g[0] = g[0] | (p0[0] & cin);
        p  = p0;
        // Up-sweep: build group terms at power-of-two boundaries.
        for (int l = 0; l < 5; l++) begin
            for (int i = 0; i < 32; i++) begin
                if (((i + 1) % (2 << l)) == 0) begin
                    g[i] = g[i] | (p[i] & g[i - (1 << l)]);
                    p[i] = p[i] & p[i - (1 << l)];
                end
            end
        end
        // Down-sweep: fill in the remaining prefix positions.
        for (int l = 3; l >= 0; l--) begin
            for (int i = 0; i < 32; i++) begin
                if ((((i + 1) % (2 << l)) == (1 << l)) && (i >= (2 << l))) begin
                    g[i] = g[i] | (p[i] & g[i - (1 << l)]);
                    p[i] = p[i] & p[i - (1 << l)];
                end
            end
        end
        sum  = p0 ^ {g[30:0], cin};
        cout = g[31];
    end

endmodule

// File: rtl/bk_adder_mp_scheduler.sv
// Shares one Brent-Kung adder among NUM_REQ requesters, round-robin, and
// sequences multi-word add/sub one word per cycle, LSW first.
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   bus   : request/response bundle (slave side)
//
// state  | meaning
// IDLE   | no transaction open; arbiter picks the next owner
// LOCKED | owner_q mid-transaction; only owner_q may issue words
module bk_adder_mp_scheduler
    import bk_adder_mp_scheduler_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    bk_adder_mp_scheduler_if.slave  bus
);
    localparam int ID_W = $clog2(NUM_REQ);

    state_e             state_q;
    logic [ID_W-1:0]    rr_ptr_q;
    logic [ID_W-1:0]    owner_q;
    logic               carry_q;
    logic               sub_q;
    logic               rsp_valid_q;
    rsp_t               rsp_q;

    logic [NUM_REQ-1:0] arb_grant;
    logic [ID_W-1:0]    arb_idx;
    logic [NUM_REQ-1:0] gnt_vec;
    logic [ID_W-1:0]    gnt_idx;
    logic               locked;
    logic               can_issue;
    logic               accept;
    logic               sub_eff;
    logic               cin;
    logic               last;
    logic [31:0]        op1;
    logic [31:0]        op2;
    logic [31:0]        sum;
    logic               cout;
    logic               ovf;

    bk_adder_mp_scheduler_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req   (bus.req_valid),
        .ptr   (rr_ptr_q),
        .grant (arb_grant),
        .idx   (arb_idx)
    );

    brent_kung_adder_32bit u_add (
        .a    (op1),
        .b    (op2),
        .cin  (cin),
        .sum  (sum),
        .cout (cout)
    );

    always_comb begin
        locked    = (state_q == LOCKED);
        gnt_idx   = locked ? owner_q : arb_idx;
        gnt_vec   = locked ? (bus.req_valid & (NUM_REQ'(1) << owner_q)) : arb_grant;
        // Output register can take a new word when empty or being drained.
        can_issue = !rsp_valid_q || bus.rsp_ready;
        accept    = can_issue && (|gnt_vec);
        sub_eff   = locked ? sub_q : bus.req_sub[gnt_idx];
        op1       = bus.req_op1[gnt_idx];
        op2       = sub_eff ? ~bus.req_op2[gnt_idx] : bus.req_op2[gnt_idx];
        cin       = locked ? carry_q : sub_eff;
        last      = bus.req_last[gnt_idx];
        ovf       = last && (op1[31] == op2[31]) && (sum[31] != op1[31]);
    end

    assign bus.req_ready = (accept && rst_n) ? gnt_vec : '0;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_res   = rsp_q.res;
    assign bus.rsp_cout  = rsp_q.cout;
    assign bus.rsp_ovf   = rsp_q.ovf;
    assign bus.rsp_id    = rsp_q.id[ID_W-1:0];
    assign bus.rsp_last  = rsp_q.last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            carry_q     <= 1'b0;
            sub_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_q       <= '0;
        end else if (accept) begin
            rsp_valid_q <= 1'b1;
            rsp_q.res   <= sum;
            rsp_q.cout  <= cout;
            rsp_q.ovf   <= ovf;
            rsp_q.id    <= ID_MAX_W'(gnt_idx);
            rsp_q.last  <= last;
            if (!locked) begin
                sub_q   <= bus.req_sub[gnt_idx];
                owner_q <= gnt_idx;
            end
            if (last) begin
                state_q  <= IDLE;
                carry_q  <= 1'b0;
                rr_ptr_q <= ID_W'(next_ptr(ID_MAX_W'(gnt_idx), NUM_REQ));
            end else begin
                state_q <= LOCKED;
                carry_q <= cout;
            end
        end else if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
        end
    end

endmodule
